segment_display_ctl: RTL and testbench
======================================

# segment_display_ctl

Scan controller for the board's 8-digit seven-segment display. It accepts a 32-bit hex value, a per-digit enable mask and decimal points through a valid/ready write port, and double-buffers them. Each new value is committed only at a frame boundary, so the display never tears. It time-multiplexes the active-low anode and cathode pins with an inter-digit blanking gap and optional brightness PWM. It sits between the CPU's display register and the board-level dsp_anode_o / dsp_cathode_o pins.

## Interface
- CYCLES_PER_DIGIT, 10000: DRIVE window length per digit in clk_sys_i cycles; must be ≥8 and a multiple of 8.
- BLANK_CYCLES, 100: all-anodes-off gap before each digit (anti-ghosting); must be ≥1.
- clk_sys_i  in  1  system clock.
- reset_async_ni  in  1  asynchronous, active-low reset.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  controller can accept a write.
- wr_value_i  in  32  hex value; digit d shows wr_value_i[4d+3:4d].
- wr_enable_i  in  8  per-digit enable; 0 = digit dark.
- wr_dp_i  in  8  per-digit decimal point.
- brightness_i  in  3  brightness level 0..7 (used only with PWM, see Configuration).
- dsp_anode_o  out  8  active-low digit selects; bit d = digit d.
- dsp_cathode_o  out  8  active-low segments; bit0=a … bit6=g, bit7=dp.
- frame_o  out  1  one-cycle pulse at each frame boundary.

## Operation
- State machine has two states: BLANK (BLANK_CYCLES cycles) and DRIVE (CYCLES_PER_DIGIT cycles). The cycle counter reloads on each transition.
- Sequence: BLANK(d) → DRIVE(d) → BLANK(d+1).
- Digit index d runs 0..7 and wraps 7→0.
- Frame boundary is the last cycle of DRIVE(7). frame_o is high on that cycle.
- Registers:
  - Active set: value, enable, dp. Drives the display.
  - Shadow set: holds the same fields plus a pending flag.
- Write handshake:
  - wr_ready_o = !pending.
  - A transfer occurs on a cycle with wr_valid_i && wr_ready_o. It loads the shadow set and sets pending.
- Commit: at a frame boundary with pending set, shadow → active and pending clears. wr_ready_o returns high on the next cycle.
- A transfer on the frame-boundary cycle itself (pending was clear) is not committed at that boundary. It waits for the next one.
- Output drive:
  - BLANK: anode = 8'hFF, cathode = 8'hFF.
  - DRIVE(d) with enable[d] = 1: anode bit d low, all other anode bits high. cathode = ~{dp[d], seg7(value nibble d)}.
  - DRIVE(d) with enable[d] = 0: anode = 8'hFF, cathode = 8'hFF.
- Hex decode covers 0–F, with lowercase b and d.
- Reset (asynchronous, anytime, including mid-frame or with a write pending):
  - anode = 8'hFF, cathode = 8'hFF, frame_o = 0, wr_ready_o = 1.
  - State BLANK, d = 0, counter reloaded.
  - Active and shadow sets cleared (value 0, enable 0, dp 0). pending = 0.

## Timing
- anode, cathode and frame_o are registered. They reflect the state/digit of the same cycle; there is no extra pipeline stage.
- Frame length = 8 × (BLANK_CYCLES + CYCLES_PER_DIGIT) cycles.
- Write-to-display latency: committed data first appears at DRIVE(0) of the frame after commit, i.e. BLANK_CYCLES + 1 cycles after the boundary.
- wr_ready_o is low from the cycle after the transfer through the commit cycle inclusive.
- Release of reset_async_ni takes effect at the first clk_sys_i edge; BLANK(0) starts counting there.

## Configuration
- SEGDISP_PWM_EN defined:
  - brightness_i is sampled on the first cycle of each DRIVE.
  - The anode is asserted only for the first (brightness+1) × CYCLES_PER_DIGIT / 8 cycles of the window. It is high for the remainder, with cathode = 8'hFF.
  - Brightness 7 gives the full window.
- SEGDISP_PWM_EN undefined: brightness_i is ignored, every enabled digit is driven for the full DRIVE window, and no PWM comparator is built.

## Structure
- Package segdisp_pkg:
  - Constant DIGITS = 8.
  - typedef for the 4-bit digit nibble.
  - typedef for the 8-bit segment vector.
  - enum for the BLANK/DRIVE state.
- Sub-module seg7_decode: combinational nibble → 7 active-high segments, instantiated once on the muxed nibble.

## Test plan
Run with CYCLES_PER_DIGIT=16, BLANK_CYCLES=2.
- Reset check: hold reset_async_ni low mid-DRIVE(3) → anode=FF, cathode=FF, wr_ready_o=1, frame_o=0. After release, the next DRIVE is digit 0.
- Write 0x12345678, enable FF, dp 00 → commit at the next frame_o. The following frame shows:
  - DRIVE(0): anode FE, cathode ~8'h7F (digit 8).
  - DRIVE(7): anode 7F, cathode ~8'h06 (digit 1).
- Two back-to-back writes → wr_ready_o falls after the first, and the second is held until the cycle after commit. A write on the frame_o cycle is displayed one frame later.
- Enable 8'b0000_0101, dp 8'h01 → only digits 0 and 2 drive, and digit 0 has cathode bit7 low. Anode stays FF during DRIVE(1) and DRIVE(3..7).
- With SEGDISP_PWM_EN, brightness 0 → each enabled DRIVE asserts its anode for exactly 2 of 16 cycles. Brightness 7 → 16 of 16.
- Reset asserted while a write is pending → pending is cleared, and nothing is displayed after release (enable 0, all FF).

Source files
------------

// File: rtl/segdisp_pkg.sv
// Shared types for the seven-segment scan controller: digit count, nibble/segment
// vectors, scan state encoding and the value/enable/dp register set.
package segdisp_pkg;

  localparam int DIGITS = 8;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] seg_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  enable;
    logic [7:0]  dp;
  } disp_set_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high segments (bit0=a .. bit6=g), lowercase b and d.
// Purely combinational, no handshake.
module seg7_decode
  import segdisp_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    case (nibble)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end

endmodule

// File: rtl/segment_display_ctl.sv
// 8-digit scan controller, double-buffered writes committed at frame boundaries; pins registered, no extra stage.
// wr_ready_o drops from transfer until commit; SEGDISP_PWM_EN adds brightness PWM within each DRIVE window.
module segment_display_ctl
  import segdisp_pkg::*;
#(
  parameter int CYCLES_PER_DIGIT = 10000,
  parameter int BLANK_CYCLES     = 100
) (
  input  logic        clk_sys_i,
  input  logic        reset_async_ni,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_value_i,
  input  logic [7:0]  wr_enable_i,
  input  logic [7:0]  wr_dp_i,
  input  logic [2:0]  brightness_i,
  output logic [7:0]  dsp_anode_o,
  output logic [7:0]  dsp_cathode_o,
  output logic        frame_o
);

  localparam int MAX_CYC = (CYCLES_PER_DIGIT > BLANK_CYCLES) ? CYCLES_PER_DIGIT : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(CYCLES_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  disp_set_t        active_q, shadow_q;
  logic             pending_q;
  seg_t             anode_q, anode_d, cathode_q, cathode_d;
  logic             frame_q, frame_d;
  nibble_t          nibble;
  logic [6:0]       segments;
  logic             pwm_on;
  logic             xfer;

  // Scan sequencer: counter counts down and reloads on each state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    digit_d = digit_q;
    if (cnt_q == '0) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_DRIVE;
        cnt_d   = DRIVE_LOAD;
      end else begin
        state_d = ST_BLANK;
        cnt_d   = BLANK_LOAD;
        digit_d = digit_q + 3'd1;
      end
    end
  end

  assign frame_d = (state_d == ST_DRIVE) && (digit_d == LAST_DIGIT) && (cnt_d == '0);

`ifdef SEGDISP_PWM_EN
  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0] STEP = PW'(CYCLES_PER_DIGIT / 8);

  logic [2:0]    bright_q, bright_d;
  logic [PW-1:0] on_len, elapsed;

  // Brightness is latched as a DRIVE window opens and held for the whole window.
  always_comb begin
    bright_d = bright_q;
    if (state_q == ST_BLANK && state_d == ST_DRIVE) bright_d = brightness_i;
    on_len  = PW'({1'b0, bright_d} + 4'd1) * STEP;
    elapsed = {1'b0, DRIVE_LOAD} - {1'b0, cnt_d};
    pwm_on  = elapsed < on_len;
  end

  always_ff @(posedge clk_sys_i or negedge reset_async_ni) begin
    if (!reset_async_ni) bright_q <= '0;
    else                 bright_q <= bright_d;
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;
  assign pwm_on            = 1'b1;
`endif

  // Outputs are computed from the next scan position so the pins line up with the state register.
  assign nibble = active_q.value[{digit_d, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble   (nibble),
    .segments (segments)
  );

  always_comb begin
    anode_d   = 8'hFF;
    cathode_d = 8'hFF;
    if (state_d == ST_DRIVE && active_q.enable[digit_d] && pwm_on) begin
      anode_d   = ~(8'h01 << digit_d);
      cathode_d = ~{active_q.dp[digit_d], segments};
    end
  end

  always_ff @(posedge clk_sys_i or negedge reset_async_ni) begin
    if (!reset_async_ni) begin
      state_q   <= ST_BLANK;
      cnt_q     <= BLANK_LOAD;
      digit_q   <= '0;
      anode_q   <= 8'hFF;
      cathode_q <= 8'hFF;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      frame_q   <= frame_d;
    end
  end

  // frame_q is high during the boundary cycle itself, so it doubles as the commit strobe.
  assign xfer = wr_valid_i && !pending_q;

  always_ff @(posedge clk_sys_i or negedge reset_async_ni) begin
    if (!reset_async_ni) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else if (xfer) begin
      shadow_q  <= '{value: wr_value_i, enable: wr_enable_i, dp: wr_dp_i};
      pending_q <= 1'b1;
    end else if (frame_q && pending_q) begin
      active_q  <= shadow_q;
      pending_q <= 1'b0;
    end
  end

  assign wr_ready_o    = !pending_q;
  assign dsp_anode_o   = anode_q;
  assign dsp_cathode_o = cathode_q;
  assign frame_o       = frame_q;

endmodule

// File: tb/tb_segment_display_ctl.sv
// Randomized bench: writes are queued on transfer, a monitor walks a frame-position model and
// compares every pin per digit slot, plus reset, ready and frame timing.
module tb_segment_display_ctl;

  localparam int C = 16;
  localparam int B = 2;
  localparam int S = B + C;
  localparam int F = 8 * S;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_value = '0;
  logic [7:0]  wr_enable = '0;
  logic [7:0]  wr_dp = '0;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  anode, cathode;
  logic        frame;

  always #5 clk_sys = ~clk_sys;

  segment_display_ctl #(.CYCLES_PER_DIGIT(C), .BLANK_CYCLES(B)) dut (
    .clk_sys_i      (clk_sys),
    .reset_async_ni (rst_n),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_value_i     (wr_value),
    .wr_enable_i    (wr_enable),
    .wr_dp_i        (wr_dp),
    .brightness_i   (brightness),
    .dsp_anode_o    (anode),
    .dsp_cathode_o  (cathode),
    .frame_o        (frame)
  );

  typedef struct {
    logic [31:0] value;
    logic [7:0]  en;
    logic [7:0]  dp;
    int          tag;
  } wr_t;

  wr_t         q[$];
  logic [31:0] disp_value = '0;
  logic [7:0]  disp_en = '0;
  logic [7:0]  disp_dp = '0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pos = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Monitor: pos is the cycle's place in the frame; slot = BLANK+DRIVE of one digit.
  initial begin : monitor
    logic [7:0] ea, ec;
    logic       er, ef, ok, lit;
    int         d, w, bs;
    string      msg;
    wr_t        it;
    ok = 1'b1;
    bs = 7;
    msg = "";
    forever begin
      @(negedge clk_sys);
      if (!rst_n) begin
        total++;
        if (anode !== 8'hFF || cathode !== 8'hFF || wr_ready !== 1'b1 || frame !== 1'b0) begin
          bad++;
          $display("FAIL reset: anode=%h cathode=%h ready=%b frame=%b, want ff ff 1 0",
                   anode, cathode, wr_ready, frame);
        end
        q.delete();
        disp_value = '0;
        disp_en = '0;
        disp_dp = '0;
        pos = 0;
        ok = 1'b1;
      end else begin
        d = pos / S;
        w = pos % S;
        if (w == B - 1) bs = int'(brightness);
        ea = 8'hFF;
        ec = 8'hFF;
        if (w >= B && disp_en[d]) begin
          lit = 1'b1;
`ifdef SEGDISP_PWM_EN
          if (w - B >= (bs + 1) * C / 8) lit = 1'b0;
`endif
          if (lit) begin
            ea = ~(8'd1 << d);
            ec = ~{disp_dp[d], seg(disp_value[4*d +: 4])};
          end
        end
        er = !(q.size() > 0 && q[0].tag < cyc);
        ef = (pos == F - 1);
        if (ok && {anode, cathode, wr_ready, frame} !== {ea, ec, er, ef}) begin
          ok = 1'b0;
          msg = $sformatf("pos=%0d got anode=%h cathode=%h ready=%b frame=%b, want %h %h %b %b",
                          pos, anode, cathode, wr_ready, frame, ea, ec, er, ef);
        end
        if (w == S - 1) begin
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL slot digit %0d: %s", d, msg);
          end
          ok = 1'b1;
        end
        if (pos == F - 1 && q.size() > 0 && q[0].tag < cyc) begin
          it = q.pop_front();
          disp_value = it.value;
          disp_en = it.en;
          disp_dp = it.dp;
        end
        pos = (pos + 1) % F;
      end
    end
  end

  initial begin : bright_drive
    forever begin
      @(posedge clk_sys);
      #1;
      brightness = 3'($urandom_range(0, 7));
    end
  end

  task automatic do_write(input logic [31:0] v, input logic [7:0] e, input logic [7:0] p);
    wr_t it;
    bit  done;
    done = 1'b0;
    wr_valid = 1'b1;
    wr_value = v;
    wr_enable = e;
    wr_dp = p;
    for (int i = 0; i < 4 * F && !done; i++) begin
      @(negedge clk_sys);
      if (wr_ready === 1'b1) begin
        it.value = v;
        it.en = e;
        it.dp = p;
        it.tag = cyc;
        q.push_back(it);
        done = 1'b1;
      end
      @(posedge clk_sys);
      #1;
    end
    wr_valid = 1'b0;
    wr_value = $urandom;
    wr_enable = 8'($urandom);
    wr_dp = 8'($urandom);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL write timeout: ready=%b, want 1 within %0d cycles", wr_ready, 4 * F);
    end
  endtask

  task automatic wait_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * F && !hit; i++) begin
      @(posedge clk_sys);
      #1;
      if (pos == p) hit = 1'b1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_pos: position %0d, want %0d", pos, p);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n * F) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    wait_frames(1);

    do_write(32'h1234_5678, 8'hFF, 8'h00);
    wait_frames(2);

    do_write($urandom, 8'($urandom), 8'($urandom));
    do_write($urandom, 8'hFF, 8'($urandom));
    wait_frames(2);

    wait_pos(F - 1);
    do_write(32'h9ABC_DEF0, 8'hFF, 8'hAA);
    wait_frames(3);

    do_write(32'h0000_0B0D, 8'b0000_0101, 8'h01);
    wait_frames(2);

    wait_pos(3 * S + B + 5);
    pulse_reset();
    wait_frames(1);
    do_write(32'hFEDC_BA98, 8'hFF, 8'hFF);
    wait_frames(2);

    wait_pos(10);
    do_write(32'h5555_5555, 8'hFF, 8'hFF);
    @(posedge clk_sys);
    #1;
    pulse_reset();
    wait_frames(2);

    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 300)) @(posedge clk_sys);
      #1;
      do_write($urandom, 8'($urandom), 8'($urandom));
    end
    wait_frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
